// File: rtl/fp_exp_update_if.sv
// Handshake and datapath bundle for the fp_exp_update_pipe exponent-update stage.
// The sticky/count signals only carry data when FP_EXP_UPDATE_STICKY_EN is defined.
`timescale 1ns/1ps
interface fp_exp_update_if #(
   parameter int EW    = 8,
   parameter int MW    = 23,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [EW+1:0]    internal_exponent;
   logic [MW:0]      mantissa_mux_out;
   logic [MW+3:0]    sum;
   logic             eop;
   logic             zero_d;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [EW-1:0]    e_exponent_update;
   logic             max_exponent_z;
   logic             min_exponent_z;
   logic [EW+1:0]    excessive_shift_left;
   logic             underflow_flag;
   logic [TAG_W-1:0] out_tag;
   logic             sticky_clr;
   logic             ovf_sticky;
   logic             unf_sticky;
   logic [15:0]      unf_count;

   modport master (
      output in_valid, internal_exponent, mantissa_mux_out, sum, eop, zero_d, in_tag,
             out_ready, sticky_clr,
      input  in_ready, out_valid, e_exponent_update, max_exponent_z, min_exponent_z,
             excessive_shift_left, underflow_flag, out_tag, ovf_sticky, unf_sticky, unf_count
   );

   modport slave (
      input  in_valid, internal_exponent, mantissa_mux_out, sum, eop, zero_d, in_tag,
             out_ready, sticky_clr,
      output in_ready, out_valid, e_exponent_update, max_exponent_z, min_exponent_z,
             excessive_shift_left, underflow_flag, out_tag, ovf_sticky, unf_sticky, unf_count
   );
endinterface

// File: rtl/fp_exp_update_pipe.sv
// Exponent-update stage: classifies the widened exponent and registers the result behind a valid/ready slot.
// Optional exception stickies and underflow counter are enabled by FP_EXP_UPDATE_STICKY_EN.
`timescale 1ns/1ps
module fp_exp_update_pipe #(
   parameter int EW    = 8,
   parameter int MW    = 23,
   parameter int TAG_W = 4
) (
   input logic           clk,
   input logic           rst,
   fp_exp_update_if.slave bus
);
   localparam int IW = EW + 2;
   localparam logic [IW-1:0] IE_TOP = {2'b00, {EW{1'b1}}};

   logic [IW-1:0]    ie_s;
   logic             cancel_s;
   logic             accept_s;
   logic [EW-1:0]    exp_s;
   logic             max_s;
   logic             min_s;
   logic             unf_s;
   logic [IW-1:0]    shift_s;

   logic             valid_r;
   logic [EW-1:0]    exp_r;
   logic             max_r;
   logic             min_r;
   logic             unf_r;
   logic [IW-1:0]    shift_r;
   logic [TAG_W-1:0] tag_r;

   logic             unused_mant_s;

   assign ie_s          = bus.internal_exponent;
   assign cancel_s      = (bus.sum == {(MW+4){1'b0}}) && bus.eop && bus.zero_d;
   assign unused_mant_s = bus.mantissa_mux_out[MW];

   // Reset forces readiness so the stage never appears blocked while being cleared.
   assign bus.in_ready = rst || !valid_r || bus.out_ready;
   assign accept_s     = bus.in_valid && bus.in_ready && !rst;

   // Classification, first match wins; bit EW+1 set with bit EW clear falls to the pass-through case.
   always_comb begin
      exp_s   = {EW{1'b0}};
      max_s   = 1'b0;
      min_s   = 1'b0;
      unf_s   = 1'b0;
      shift_s = {IW{1'b0}};
      if (cancel_s) begin
         min_s = 1'b1;
      end else if ((ie_s[EW] && !ie_s[EW+1]) || (ie_s == IE_TOP)) begin
         exp_s = {EW{1'b1}};
         max_s = 1'b1;
      end else if (ie_s[EW+1] && ie_s[EW]) begin
         min_s   = 1'b1;
         unf_s   = 1'b1;
         shift_s = ~ie_s + {{(IW-1){1'b0}}, 1'b1};
      end else if (ie_s == {IW{1'b0}}) begin
         if (bus.sum[MW+3]) begin
            exp_s = {{(EW-1){1'b0}}, 1'b1};
         end else begin
            min_s = 1'b1;
            unf_s = |bus.mantissa_mux_out[MW-1:0];
         end
      end else begin
         exp_s = ie_s[EW-1:0];
      end
   end

   // Single-entry output register: load on transfer, drop valid when drained without refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         exp_r   <= {EW{1'b0}};
         max_r   <= 1'b0;
         min_r   <= 1'b0;
         unf_r   <= 1'b0;
         shift_r <= {IW{1'b0}};
         tag_r   <= {TAG_W{1'b0}};
      end else if (accept_s) begin
         valid_r <= 1'b1;
         exp_r   <= exp_s;
         max_r   <= max_s;
         min_r   <= min_s;
         unf_r   <= unf_s;
         shift_r <= shift_s;
         tag_r   <= bus.in_tag;
      end else if (bus.out_ready) begin
         valid_r <= 1'b0;
      end
   end

   assign bus.out_valid            = valid_r;
   assign bus.e_exponent_update    = exp_r;
   assign bus.max_exponent_z       = max_r;
   assign bus.min_exponent_z       = min_r;
   assign bus.excessive_shift_left = shift_r;
   assign bus.underflow_flag       = unf_r;
   assign bus.out_tag              = tag_r;

`ifdef FP_EXP_UPDATE_STICKY_EN
   logic        ovf_evt_s;
   logic        unf_evt_s;
   logic        ovf_sticky_r;
   logic        unf_sticky_r;
   logic [15:0] unf_count_r;

   assign ovf_evt_s = accept_s && max_s;
   assign unf_evt_s = accept_s && unf_s;

   // Exception accumulation; an event coinciding with a clear survives the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_sticky_r <= 1'b0;
         unf_sticky_r <= 1'b0;
         unf_count_r  <= 16'h0000;
      end else if (bus.sticky_clr) begin
         ovf_sticky_r <= ovf_evt_s;
         unf_sticky_r <= unf_evt_s;
         unf_count_r  <= unf_evt_s ? 16'h0001 : 16'h0000;
      end else begin
         ovf_sticky_r <= ovf_sticky_r | ovf_evt_s;
         unf_sticky_r <= unf_sticky_r | unf_evt_s;
         if (unf_evt_s && (unf_count_r != 16'hFFFF)) begin
            unf_count_r <= unf_count_r + 16'h0001;
         end
      end
   end

   assign bus.ovf_sticky = ovf_sticky_r;
   assign bus.unf_sticky = unf_sticky_r;
   assign bus.unf_count  = unf_count_r;
`else
   logic unused_clr_s;

   assign unused_clr_s   = bus.sticky_clr;
   assign bus.ovf_sticky = 1'b0;
   assign bus.unf_sticky = 1'b0;
   assign bus.unf_count  = 16'h0000;
`endif
endmodule
